// File: rtl/video_pkg.sv
// Shared video-pipeline definitions: default raster size, frame reader state
// encoding and an index-width helper.
package video_pkg;

    localparam int DEF_HDISP = 800;
    localparam int DEF_VDISP = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } reader_state_e;

    // Width of a counter addressing n words, never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wshb_frame_reader.sv
// Wishbone master that streams a linear framebuffer into a pixel FIFO.
// Optional macro WSHB_BURST_EN enables incrementing-burst cycle tags (cti/bte).
module wshb_frame_reader
    import video_pkg::*;
#(
    parameter int          HDISP     = DEF_HDISP,
    parameter int          VDISP     = DEF_VDISP,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic [31:0] dat_sm,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_afull,
    output logic        frame_start
);

    localparam int             NPIX     = HDISP * VDISP;
    localparam int             IW       = index_width(NPIX);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NPIX - 1);

    reader_state_e state, state_next;
    logic [IW-1:0] idx;
    logic          accept;
    logic          done;
    logic          leave_req;

    // Bus handshake is decoded straight from the state register, so an
    // asynchronous reset drops cyc/stb without waiting for a clock edge.
    assign stb = (state == ST_REQ);
    assign cyc = stb;
    assign we  = 1'b0;
    assign sel = 4'hF;
    assign bte = 2'b00;
    assign adr = BASE_ADDR + (32'(idx) << 2);

    assign accept    = stb & (ack | err);
    assign done      = stb & (ack | err | rty);
    assign leave_req = fifo_afull | ~enable;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable && !fifo_afull) state_next = ST_REQ;
            ST_REQ:  if (done && leave_req)     state_next = ST_HOLD;
            ST_HOLD: begin
                if (!enable)         state_next = ST_IDLE;
                else if (!fifo_afull) state_next = ST_REQ;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef WSHB_BURST_EN
    // Tag the final beat of a burst: the bus is about to be released or the frame wraps.
    always_comb begin
        cti = 3'b000;
        if (stb) cti = (leave_req || idx == LAST_IDX) ? 3'b111 : 3'b010;
    end
`else
    assign cti = 3'b000;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Pixel index: restarts at 0 whenever the reader parks in IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx <= '0;
        end else if (state == ST_IDLE || (state == ST_HOLD && state_next == ST_IDLE)) begin
            idx <= '0;
        end else if (accept) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // An error still produces a (black) pixel so the frame length stays exact.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_write  <= 1'b0;
            fifo_wdata  <= '0;
            frame_start <= 1'b0;
        end else begin
            fifo_write  <= accept;
            frame_start <= accept && (idx == '0);
            if (accept) fifo_wdata <= err ? 32'h0 : dat_sm;
        end
    end

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Self-checking bench for wshb_frame_reader: directed scenarios plus random
// slave/FIFO behaviour against a pixel-position reference model.
module tb_wshb_frame_reader;

    localparam int          HDISP = 4;
    localparam int          VDISP = 2;
    localparam int          NPIX  = HDISP * VDISP;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        fifo_afull = 1'b0;
    logic        frame_start;

    wshb_frame_reader #(.HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable),
        .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel), .cti(cti), .bte(bte),
        .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty),
        .fifo_wdata(fifo_wdata), .fifo_write(fifo_write), .fifo_afull(fifo_afull),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: next pixel position plus what was on the bus at the last edge.
    int          exp_i = 0;
    bit          p_stb = 0, p_ack = 0, p_err = 0, p_rty = 0, p_en = 0, p_afull = 0;
    logic [31:0] p_dat = '0;

    // Stimulus knobs and observation logs.
    bit          knob_en = 0, knob_afull = 0, rand_mode = 0, rty_used = 0;
    int          rty_idx = -1, err_idx = -1;
    logic [31:0] acc_q[$];
    int          wr_cnt = 0, fs_cnt = 0;
    logic [31:0] retry_adr = '0, err_next_adr = '0, err_word = 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Compare point: the falling edge after each rising edge.
    task automatic sample();
        bit exp_wr, exp_stb;
        @(negedge clk);
        if (!rst_n) begin
            exp_i = 0;
            return;
        end
        exp_wr = p_stb && (p_ack || p_err);
        check("fifo_write", {31'b0, fifo_write}, {31'b0, exp_wr});
        if (exp_wr) begin
            check("fifo_wdata", fifo_wdata, p_err ? 32'h0 : p_dat);
            check("frame_start", {31'b0, frame_start}, {31'b0, exp_i == 0});
            exp_i = (exp_i + 1) % NPIX;
        end else begin
            check("frame_start_idle", {31'b0, frame_start}, 32'h0);
            if (!p_stb && !p_en) exp_i = 0;
        end
        if (fifo_write) wr_cnt++;
        if (frame_start) fs_cnt++;
        if (fifo_write && p_err) err_word = fifo_wdata;
        exp_stb = (p_stb && !(p_ack || p_err || p_rty)) ? 1'b1 : (p_en && !p_afull);
        check("stb", {31'b0, stb}, {31'b0, exp_stb});
        check("cyc", {31'b0, cyc}, {31'b0, exp_stb});
        check("we_sel_bte", {25'b0, we, sel, bte}, {25'b0, 1'b0, 4'hF, 2'b00});
        if (stb) check("adr", adr, BASE + 32'(exp_i * 4));
        if (stb && p_stb && p_rty) retry_adr = adr;
        if (stb && p_stb && p_err) err_next_adr = adr;
    endtask

    // Drive point: set inputs for the next rising edge, then check the burst tag.
    task automatic drive();
        logic [2:0] exp_cti;
        int r;
        enable     = knob_en;
        fifo_afull = knob_afull;
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        dat_sm = $urandom;
        if (stb && rst_n) begin
            if (rand_mode) begin
                r = $urandom_range(0, 99);
                if (r < 55)      ack = 1'b1;
                else if (r < 70) ack = 1'b0;
                else if (r < 82) rty = 1'b1;
                else if (r < 92) err = 1'b1;
                else             ack = 1'b1;
            end else if (exp_i == rty_idx && !rty_used) begin
                rty = 1'b1;
                rty_used = 1;
            end else if (exp_i == err_idx) begin
                err = 1'b1;
            end else begin
                ack = 1'b1;
            end
            if (ack || err) acc_q.push_back(adr);
        end
        p_stb = stb; p_ack = ack; p_err = err; p_rty = rty;
        p_en = enable; p_afull = fifo_afull; p_dat = dat_sm;
        #1;
`ifdef WSHB_BURST_EN
        exp_cti = !stb ? 3'b000 :
                  ((!enable || fifo_afull || exp_i == NPIX - 1) ? 3'b111 : 3'b010);
`else
        exp_cti = 3'b000;
`endif
        if (rst_n) check("cti", {29'b0, cti}, {29'b0, exp_cti});
    endtask

    initial begin
        logic [31:0] adr_tbl [9];
        logic [31:0] resume_adr, restart_adr;
        bit          resumed, dropped, restarted, restart_fs, got;
        int          afull_hold, after;

        adr_tbl = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                    32'h114, 32'h118, 32'h11C, 32'h100};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cyc", {31'b0, cyc}, 32'h0);
        check("rst_stb", {31'b0, stb}, 32'h0);
        check("rst_adr", adr, 32'h100);
        check("rst_cti_bte", {27'b0, cti, bte}, 32'h0);
        check("rst_fifo", {fifo_write, frame_start, 30'b0}, 32'h0);
        check("rst_wdata", fifo_wdata, 32'h0);
        rst_n = 1'b1;

        // Full-speed streaming across a frame wrap.
        knob_en = 1;
        for (int k = 0; k < 60 && acc_q.size() < 17; k++) begin
            sample();
            drive();
        end
        if (acc_q.size() < 17) timeout("stream");
        for (int k = 0; k < 9; k++) check($sformatf("adr_seq%0d", k), acc_q[k], adr_tbl[k]);
        knob_en = 0;
        repeat (6) begin sample(); drive(); end
        check("wr_vs_acc", 32'(wr_cnt), 32'(acc_q.size()));
        check("fs_count", 32'(fs_cnt), 32'((acc_q.size() + NPIX - 1) / NPIX));

        // FIFO almost-full during pixel 3.
        knob_en = 1; afull_hold = -1; resumed = 0; resume_adr = '0;
        for (int k = 0; k < 60 && !resumed; k++) begin
            sample();
            if (afull_hold == 0 && stb && !p_stb) begin
                resume_adr = adr;
                resumed = 1;
            end
            if (afull_hold < 0 && stb && exp_i == 3) begin
                knob_afull = 1;
                afull_hold = 4;
            end else if (afull_hold > 0) begin
                afull_hold--;
                if (afull_hold == 0) knob_afull = 0;
            end
            drive();
        end
        if (!resumed) timeout("afull_resume");
        check("afull_resume_adr", resume_adr, 32'h110);

        // Retry on pixel 2, error on pixel 5.
        rty_idx = 2; err_idx = 5; rty_used = 0; got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            sample();
            got = rty_used && (err_next_adr != 0) && (retry_adr != 0) && (err_word != 32'hFFFF_FFFF);
            drive();
        end
        if (!got) timeout("rty_err");
        check("retry_adr", retry_adr, 32'h108);
        check("err_next_adr", err_next_adr, 32'h118);
        check("err_word", err_word, 32'h0);
        rty_idx = -1; err_idx = -1;

        // Enable falls during pixel 6, then restart at pixel 0.
        dropped = 0; after = 0; restarted = 0; restart_adr = '0; restart_fs = 0;
        for (int k = 0; k < 80 && !restarted; k++) begin
            sample();
            if (dropped && after > 0 && fifo_write) begin
                restart_fs = frame_start;
                restarted = 1;
            end
            if (dropped && after > 0 && stb && !p_stb && restart_adr == 0) restart_adr = adr;
            if (dropped) begin
                after++;
                if (after == 5) knob_en = 1;
            end
            if (!dropped && stb && exp_i == 6) begin
                knob_en = 0;
                dropped = 1;
            end
            drive();
        end
        if (!restarted) timeout("restart");
        check("restart_adr", restart_adr, 32'h100);
        check("restart_fs", {31'b0, restart_fs}, 32'h1);

        // Asynchronous reset in the middle of an access.
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            sample();
            got = stb;
            drive();
        end
        if (!got) timeout("stb_before_reset");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stb", {30'b0, cyc, stb}, 32'h0);
        check("async_rst_adr", adr, 32'h100);
        repeat (3) begin sample(); drive(); end
        rst_n = 1'b1;
        repeat (20) begin sample(); drive(); end

        // Randomised slave and FIFO back-pressure.
        rand_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            sample();
            if ($urandom_range(0, 99) < 4) knob_en = !knob_en;
            knob_afull = ($urandom_range(0, 99) < 25);
            drive();
        end
        knob_en = 0; knob_afull = 0;
        repeat (30) begin sample(); drive(); end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
